alu_cmd_sequencer: RTL and testbench
====================================

# alu_cmd_sequencer

Byte-stream front end for the 8-bit `alu`. It accepts command frames over a valid/ready byte interface and decodes each opcode. It drives the `alu` operand and opcode inputs, registers the result, and returns it over a valid/ready result interface. It sits between the host byte link and the combinational `alu`, which it instantiates.

## Interface
Parameters:
- `DIV0_VALUE`, default 8'hFF: result byte returned for divide by zero.
- `CNT_W`, default 16: width of the completed-command counter.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `in_data`  in  8  command/operand byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  sequencer can accept a byte.
- `res_data`  out  8  result byte.
- `res_err`  out  1  result is an error (illegal opcode or divide by zero).
- `res_valid`  out  1  result available.
- `res_ready`  in  1  consumer accepts the result.
- `cmd_count`  out  `CNT_W`  number of completed result handshakes; wraps.

## Operation
- Frame: opcode byte, then operand A, then operand B. Operand B is omitted for NOT.
- Opcode byte layout:
  - bits 7:3 must be 0.
  - bit 2 = mode.
  - bits 1:0 = op.
- Opcode values:
  - 0x00 AND, 0x01 OR, 0x02 XOR, 0x03 NOT(A).
  - 0x04 ADD, 0x05 SUB, 0x06 DIV, 0x07 MUL.
- Arithmetic: 8-bit results, modulo 256.
  - SUB wraps.
  - MUL keeps the low 8 bits.
  - DIV is unsigned integer division.
- States:
  - IDLE (await opcode), GET_A, GET_B, EXEC, RESP.
  - IDLE -> GET_A on an opcode handshake with bits 7:3 = 0.
  - IDLE -> RESP on an illegal opcode: `res_data`=0x00, `res_err`=1, no operands consumed.
  - GET_A -> GET_B on an A handshake, or GET_A -> EXEC if the op is NOT.
  - GET_B -> EXEC on a B handshake.
  - EXEC -> RESP unconditionally.
  - RESP -> IDLE on the result handshake (`res_valid && res_ready`).
- EXEC:
  - Registers the `alu` output into `res_data` with `res_err`=0.
  - Exception: DIV with B=0x00 registers `DIV0_VALUE` with `res_err`=1. The `alu` output is ignored in that case.
- `in_ready` is 1 only in IDLE, GET_A and GET_B; 0 in EXEC and RESP.
- `res_valid` is 1 only in RESP.
- `res_data` and `res_err` are held stable while `res_valid`=1 and `res_ready`=0.
- `cmd_count` increments by 1 on each result handshake, including error results. It wraps from all-ones to 0.
- Opcode, A and B are held in internal registers. The `alu` inputs are driven only from these registers, never directly from `in_data`.

## Timing
- Reset (`rst_n`=0 at a rising edge) puts the block in IDLE:
  - `in_ready`=1 in the first cycle after reset.
  - `res_valid`=0, `res_data`=0x00, `res_err`=0, `cmd_count`=0.
  - Operand and opcode registers cleared.
- Reset mid-frame or in RESP: the partial frame or pending result is discarded and no count increments.
- A byte is consumed at a rising edge with `in_valid && in_ready`. Bubbles (`in_valid`=0) between bytes are allowed with no limit.
- Latency: last operand handshake at edge N -> EXEC in cycle N+1 -> `res_valid`=1 from edge N+2.
- Illegal opcode: `res_valid`=1 from the edge after the opcode handshake.
- RESP with `res_ready`=1 held high: exactly one cycle of `res_valid`. `in_ready` returns to 1 in the following cycle.
- Throughput: at most one command per 5 cycles (4 for NOT).
- There is no input/output overlap: no byte is accepted while a result is pending.

## Structure
- Package `alu_cmd_pkg` holds:
  - State enum: IDLE, GET_A, GET_B, EXEC, RESP.
  - Opcode localparams, matching the `alu` op encodings (ADD/SUB/DIV/MUL for mode 1, LAND/LOR/LXOR/LNOT for mode 0).
  - Mode bit position and reserved-bits mask.
- One sub-module instance: the existing `alu`, driven from the internal A/B/mode/op registers.
- The FSM, operand registers, divide-by-zero check and counter live in `alu_cmd_sequencer`.

## Test plan
- ADD: bytes 0x04, 0x05, 0x03 with `res_ready`=1 -> `res_data`=0x08, `res_err`=0, `res_valid` 2 cycles after the B handshake, `cmd_count`=1.
- Arithmetic wrap:
  - SUB 0x05, 0x03, 0x05 -> 0xFE.
  - MUL 0x07, 0x10, 0x20 -> 0x00.
  - DIV 0x06, 0x64, 0x07 -> 0x0E.
- NOT 0x03, 0x5A -> 0xA5 after only two input bytes; the next byte is treated as a new opcode.
- Error cases:
  - DIV 0x06, 0x10, 0x00 -> `res_data`=0xFF, `res_err`=1.
  - Illegal opcode 0x85 -> `res_data`=0x00, `res_err`=1 the next cycle with no operands consumed; `cmd_count` increments for both.
- Backpressure: hold `res_ready`=0 for 10 cycles in RESP -> `res_data` stable, `in_ready`=0 throughout, single count on release.
- Reset mid-frame: assert `rst_n`=0 after the opcode and A -> outputs at reset values; a following full AND frame 0x00, 0xF0, 0x3C returns 0x30.

Source files
------------

// File: rtl/alu_cmd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_cmd_pkg : shared types and encodings for alu_cmd_sequencer  |
// | Revision    : 1.0                                               |
// +-----------------------------------------------------------------+
package alu_cmd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GET_A = 3'd1,
    ST_GET_B = 3'd2,
    ST_EXEC  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Logic ops (mode 0)
  localparam logic [1:0] OP_LAND = 2'd0;
  localparam logic [1:0] OP_LOR  = 2'd1;
  localparam logic [1:0] OP_LXOR = 2'd2;
  localparam logic [1:0] OP_LNOT = 2'd3;
  // Arithmetic ops (mode 1)
  localparam logic [1:0] OP_ADD  = 2'd0;
  localparam logic [1:0] OP_SUB  = 2'd1;
  localparam logic [1:0] OP_DIV  = 2'd2;
  localparam logic [1:0] OP_MUL  = 2'd3;

  localparam int         MODE_BIT  = 2;
  localparam logic [7:0] RSVD_MASK = 8'hF8;

endpackage : alu_cmd_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu      : combinational 8-bit logic/arithmetic unit            |
// | Revision : 1.0                                                  |
// +-----------------------------------------------------------------+
module alu
  import alu_cmd_pkg::*;
(
  input  logic [7:0] i_a,
  input  logic [7:0] i_b,
  input  logic       i_mode,
  input  logic [1:0] i_op,
  output logic [7:0] o_y
);

  always_comb begin
    o_y = 8'h00;
    if (i_mode) begin
      case (i_op)
        OP_ADD:  o_y = i_a + i_b;
        OP_SUB:  o_y = i_a - i_b;
        // Zero divisor yields 0 here; the caller substitutes its own value.
        OP_DIV:  o_y = (i_b == 8'h00) ? 8'h00 : (i_a / i_b);
        default: o_y = i_a * i_b;
      endcase
    end else begin
      case (i_op)
        OP_LAND: o_y = i_a & i_b;
        OP_LOR:  o_y = i_a | i_b;
        OP_LXOR: o_y = i_a ^ i_b;
        default: o_y = ~i_a;
      endcase
    end
  end

endmodule : alu
`default_nettype wire

// File: rtl/alu_cmd_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | alu_cmd_sequencer : byte-stream command front end for the alu   |
// | Revision          : 1.0                                         |
// +-----------------------------------------------------------------+
module alu_cmd_sequencer
  import alu_cmd_pkg::*;
#(
  parameter logic [7:0] DIV0_VALUE = 8'hFF,
  parameter int         CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       res_data,
  output logic             res_err,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CNT_W-1:0] cmd_count
);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_op;
  logic             r_mode;
  logic [7:0]       r_a;
  logic [7:0]       r_b;
  logic [7:0]       r_res_data;
  logic             r_res_err;
  logic [CNT_W-1:0] r_cnt;

  logic       w_in_hs;
  logic       w_res_hs;
  logic       w_illegal;
  logic       w_is_not;
  logic       w_div0;
  logic [7:0] w_alu_y;

  assign w_in_hs   = in_valid && in_ready;
  assign w_res_hs  = res_valid && res_ready;
  assign w_illegal = |(in_data & RSVD_MASK);
  assign w_is_not  = !r_mode && (r_op == OP_LNOT);
  assign w_div0    = r_mode && (r_op == OP_DIV) && (r_b == 8'h00);

  alu u_alu (
    .i_a    (r_a),
    .i_b    (r_b),
    .i_mode (r_mode),
    .i_op   (r_op),
    .o_y    (w_alu_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_in_hs) w_next = w_illegal ? ST_RESP : ST_GET_A;
      ST_GET_A: if (w_in_hs) w_next = w_is_not ? ST_EXEC : ST_GET_B;
      ST_GET_B: if (w_in_hs) w_next = ST_EXEC;
      ST_EXEC:  w_next = ST_RESP;
      ST_RESP:  if (w_res_hs) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    res_valid = 1'b0;
    case (r_state)
      ST_IDLE, ST_GET_A, ST_GET_B: in_ready  = 1'b1;
      ST_RESP:                     res_valid = 1'b1;
      default: begin
        in_ready  = 1'b0;
        res_valid = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_op       <= 2'd0;
      r_mode     <= 1'b0;
      r_a        <= 8'h00;
      r_b        <= 8'h00;
      r_res_data <= 8'h00;
      r_res_err  <= 1'b0;
      r_cnt      <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_in_hs) begin
          r_op   <= in_data[1:0];
          r_mode <= in_data[MODE_BIT];
          if (w_illegal) begin
            r_res_data <= 8'h00;
            r_res_err  <= 1'b1;
          end
        end
        ST_GET_A: if (w_in_hs) r_a <= in_data;
        ST_GET_B: if (w_in_hs) r_b <= in_data;
        ST_EXEC: begin
          r_res_data <= w_div0 ? DIV0_VALUE : w_alu_y;
          r_res_err  <= w_div0;
        end
        default: ;
      endcase
      if (w_res_hs) r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign res_data  = r_res_data;
  assign res_err   = r_res_err;
  assign cmd_count = r_cnt;

endmodule : alu_cmd_sequencer
`default_nettype wire

// File: tb/tb_alu_cmd_sequencer.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | tb_alu_cmd_sequencer : directed self-checking bench             |
// | Revision             : 1.0                                      |
// +-----------------------------------------------------------------+
module tb_alu_cmd_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  res_data;
  logic        res_err;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] cmd_count;

  int errors    = 0;
  int checks    = 0;
  int exp_count = 0;

  alu_cmd_sequencer #(
    .DIV0_VALUE (8'hFF),
    .CNT_W      (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res_data  (res_data),
    .res_err   (res_err),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .cmd_count (cmd_count)
  );

  always #5 clk = ~clk;

  // Offers one byte at a negedge once in_ready is seen; bounded wait.
  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    for (int n = 0; n < 20 && !done; n++) begin
      @(negedge clk);
      if (in_ready) begin
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        done     = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_byte_timeout: byte=%h in_ready=%b required 1", b, in_ready);
    end
  endtask

  // Waits (bounded) for res_valid; lat = negedges seen until valid, -1 on timeout.
  task automatic get_result(output logic [7:0] d, output logic e, output int lat);
    d   = 8'h00;
    e   = 1'b0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (res_valid) begin
        d   = res_data;
        e   = res_err;
        lat = n;
        break;
      end
    end
    if (lat > 0) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    res_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_count = 0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
    checks++; if (res_data !== 8'h00) begin errors++; $display("FAIL reset_res_data: got %h want 00", res_data); end
    checks++; if (res_err !== 1'b0) begin errors++; $display("FAIL reset_res_err: got %b want 0", res_err); end
    checks++; if (cmd_count !== 16'd0) begin errors++; $display("FAIL reset_cmd_count: got %0d want 0", cmd_count); end
  endtask

  task automatic test_add();
    logic [7:0] d; logic e; int lat;
    send_byte(8'h04); send_byte(8'h05); send_byte(8'h03);
    get_result(d, e, lat);
    exp_count++;
    checks++; if (lat !== 2) begin errors++; $display("FAIL add_latency: got %0d want 2", lat); end
    checks++; if (d !== 8'h08) begin errors++; $display("FAIL add_data: got %h want 08", d); end
    checks++; if (e !== 1'b0) begin errors++; $display("FAIL add_err: got %b want 0", e); end
    checks++; if (cmd_count !== 16'(exp_count)) begin errors++; $display("FAIL add_count: got %0d want %0d", cmd_count, exp_count); end
    checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL add_return_idle: in_ready=%b res_valid=%b want 1 0", in_ready, res_valid); end
  endtask

  task automatic test_arith();
    logic [7:0] vec [3][4];
    logic [7:0] d; logic e; int lat;
    vec[0] = '{8'h05, 8'h03, 8'h05, 8'hFE};  // SUB wraps
    vec[1] = '{8'h07, 8'h10, 8'h20, 8'h00};  // MUL low byte
    vec[2] = '{8'h06, 8'h64, 8'h07, 8'h0E};  // DIV
    for (int i = 0; i < 3; i++) begin
      send_byte(vec[i][0]); send_byte(vec[i][1]); send_byte(vec[i][2]);
      get_result(d, e, lat);
      exp_count++;
      checks++; if (d !== vec[i][3] || e !== 1'b0) begin errors++; $display("FAIL arith_op%h: got data=%h err=%b want data=%h err=0", vec[i][0], d, e, vec[i][3]); end
    end
    checks++; if (cmd_count !== 16'(exp_count)) begin errors++; $display("FAIL arith_count: got %0d want %0d", cmd_count, exp_count); end
  endtask

  task automatic test_not();
    logic [7:0] d; logic e; int lat;
    send_byte(8'h03); send_byte(8'h5A);
    get_result(d, e, lat);
    exp_count++;
    checks++; if (lat !== 2) begin errors++; $display("FAIL not_latency: got %0d want 2", lat); end
    checks++; if (d !== 8'hA5 || e !== 1'b0) begin errors++; $display("FAIL not_data: got data=%h err=%b want A5 0", d, e); end
    send_byte(8'h02); send_byte(8'hFF); send_byte(8'h0F);
    get_result(d, e, lat);
    exp_count++;
    checks++; if (d !== 8'hF0 || e !== 1'b0) begin errors++; $display("FAIL not_next_opcode: got data=%h err=%b want F0 0", d, e); end
  endtask

  task automatic test_errors();
    logic [7:0] d; logic e; int lat;
    send_byte(8'h06); send_byte(8'h10); send_byte(8'h00);
    get_result(d, e, lat);
    exp_count++;
    checks++; if (d !== 8'hFF || e !== 1'b1) begin errors++; $display("FAIL div0: got data=%h err=%b want FF 1", d, e); end
    send_byte(8'h85);
    get_result(d, e, lat);
    exp_count++;
    checks++; if (lat !== 1) begin errors++; $display("FAIL illegal_latency: got %0d want 1", lat); end
    checks++; if (d !== 8'h00 || e !== 1'b1) begin errors++; $display("FAIL illegal_data: got data=%h err=%b want 00 1", d, e); end
    checks++; if (cmd_count !== 16'(exp_count)) begin errors++; $display("FAIL error_count: got %0d want %0d", cmd_count, exp_count); end
    send_byte(8'h04); send_byte(8'h01); send_byte(8'h02);
    get_result(d, e, lat);
    exp_count++;
    checks++; if (d !== 8'h03 || e !== 1'b0) begin errors++; $display("FAIL after_illegal: got data=%h err=%b want 03 0", d, e); end
  endtask

  task automatic test_backpressure();
    bit seen;
    int bad;
    res_ready = 1'b0;
    send_byte(8'h04); send_byte(8'h10); send_byte(8'h20);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      @(negedge clk);
      if (res_valid) seen = 1'b1;
    end
    checks++; if (!seen) begin errors++; $display("FAIL bp_valid_timeout: res_valid=%b want 1", res_valid); end
    bad = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (res_valid !== 1'b1 || res_data !== 8'h30 || res_err !== 1'b0 ||
          in_ready !== 1'b0 || cmd_count !== 16'(exp_count)) begin
        bad++;
        $display("FAIL bp_hold cyc%0d: valid=%b data=%h err=%b in_ready=%b count=%0d want 1 30 0 0 %0d",
                 n, res_valid, res_data, res_err, in_ready, cmd_count, exp_count);
      end
    end
    checks++; if (bad != 0) errors++;
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    exp_count++;
    checks++; if (cmd_count !== 16'(exp_count)) begin errors++; $display("FAIL bp_release_count: got %0d want %0d", cmd_count, exp_count); end
    checks++; if (res_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_state: valid=%b in_ready=%b want 0 1", res_valid, in_ready); end
    @(negedge clk);
    checks++; if (cmd_count !== 16'(exp_count)) begin errors++; $display("FAIL bp_single_count: got %0d want %0d", cmd_count, exp_count); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] d; logic e; int lat;
    send_byte(8'h04); send_byte(8'h11);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    exp_count = 0;
    checks++; if (in_ready !== 1'b1 || res_valid !== 1'b0) begin errors++; $display("FAIL midrst_ctrl: in_ready=%b valid=%b want 1 0", in_ready, res_valid); end
    checks++; if (res_data !== 8'h00 || res_err !== 1'b0) begin errors++; $display("FAIL midrst_res: data=%h err=%b want 00 0", res_data, res_err); end
    checks++; if (cmd_count !== 16'd0) begin errors++; $display("FAIL midrst_count: got %0d want 0", cmd_count); end
    send_byte(8'h00); send_byte(8'hF0); send_byte(8'h3C);
    get_result(d, e, lat);
    exp_count++;
    checks++; if (d !== 8'h30 || e !== 1'b0) begin errors++; $display("FAIL midrst_and: got data=%h err=%b want 30 0", d, e); end
    checks++; if (cmd_count !== 16'(exp_count)) begin errors++; $display("FAIL midrst_and_count: got %0d want %0d", cmd_count, exp_count); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_arith();
    test_not();
    test_errors();
    test_backpressure();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_alu_cmd_sequencer
`default_nettype wire
